// File: rtl/cp_rca_pkg.sv
// -----------------------------------------------------------------------------
// cp_rca_pkg
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   MODE_ADD / MODE_SUB : encodings of the i_sub operation select
//   cfg_ok()            : legality check of the WIDTH / SEG_W pairing,
//                         used by the top to stop elaboration on a bad pair
// -----------------------------------------------------------------------------
package cp_rca_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // WIDTH must split into a whole, non-zero number of SEG_W-bit segments.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned seg_w);
    return (seg_w != 32'd0) && (width >= seg_w) && ((width % seg_w) == 32'd0);
  endfunction

endpackage

// File: rtl/cp_full_add_str.sv
// -----------------------------------------------------------------------------
// cp_full_add_str
// Structural one-bit full adder (gate primitives).
//   i_a, i_b : addend bits
//   i_c      : carry in
//   o_s      : sum bit
//   o_c      : carry out
// -----------------------------------------------------------------------------
module cp_full_add_str (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_p;
  logic w_g;
  logic w_t;

  xor u_x_p (w_p, i_a, i_b);
  xor u_x_s (o_s, w_p, i_c);
  and u_a_g (w_g, i_a, i_b);
  and u_a_t (w_t, w_p, i_c);
  or  u_o_c (o_c, w_g, w_t);

endmodule

// File: rtl/cp_rca_seg.sv
// -----------------------------------------------------------------------------
// cp_rca_seg
// Purely combinational SEG_W-bit ripple segment built from cp_full_add_str.
//   i_a, i_b : segment operand slices (i_b already inverted for subtract)
//   i_c      : carry into the segment LSB
//   o_s      : segment sum
//   o_co     : carry out of the segment MSB
//   o_cm     : carry into the segment MSB (overflow detection at the top)
// -----------------------------------------------------------------------------
module cp_rca_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_c,
  output logic [SEG_W-1:0] o_s,
  output logic             o_co,
  output logic             o_cm
);

  logic [SEG_W:0] w_c;

  assign w_c[0] = i_c;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    cp_full_add_str u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_c[i]),
      .o_s (o_s[i]),
      .o_c (w_c[i+1])
    );
  end

  assign o_co = w_c[SEG_W];
  assign o_cm = w_c[SEG_W-1];

endmodule

// File: rtl/cp_rca_pipe.sv
// -----------------------------------------------------------------------------
// cp_rca_pipe
// Pipelined WIDTH-bit ripple-carry adder/subtractor, one SEG_W-bit segment
// per register stage, valid/ready handshake on both sides, latency NUM_SEG.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/o_ready: upstream handshake (o_ready = pipeline may advance)
//   i_a, i_b       : operands
//   i_cin          : carry-in (add) / borrow-in (sub)
//   i_sub          : MODE_ADD = A+B+cin, MODE_SUB = A-B-cin
//   o_valid/i_ready: downstream handshake
//   o_s            : sum/difference modulo 2^WIDTH
//   o_cy           : carry out of MSB (not-borrow when subtracting)
//   o_ovf          : two's-complement overflow
// -----------------------------------------------------------------------------
module cp_rca_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cy,
  output logic             o_ovf
);

  import cp_rca_pkg::*;

  localparam int NUM_SEG = WIDTH / SEG_W;

  if (!cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
    $error("cp_rca_pipe: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_beff;
  logic             w_ceff;

  // Per-stage inputs: operands still to be summed (next slice at the bottom),
  // incoming carry, partial sum assembled so far and incoming valid.
  logic [WIDTH-1:0] w_a    [NUM_SEG];
  logic [WIDTH-1:0] w_b    [NUM_SEG];
  logic [WIDTH-1:0] w_sp   [NUM_SEG];
  logic             w_c    [NUM_SEG];
  logic             w_vin  [NUM_SEG];
  logic [SEG_W-1:0] w_seg_s  [NUM_SEG];
  logic             w_seg_co [NUM_SEG];
  logic             w_seg_cm [NUM_SEG];

  logic             r_vld [NUM_SEG];
  logic [WIDTH-1:0] r_s   [NUM_SEG];
  logic [WIDTH-1:0] r_a   [NUM_SEG];
  logic [WIDTH-1:0] r_b   [NUM_SEG];
  logic             r_c   [NUM_SEG];
  logic             r_ovf;

  // Subtraction is A + ~B + ~borrow, so only B and the carry-in are bent.
  always_comb begin
    w_beff = i_b;
    w_ceff = i_cin;
    if (i_sub == MODE_SUB) begin
      w_beff = ~i_b;
      w_ceff = ~i_cin;
    end else begin
      w_beff = i_b;
      w_ceff = i_cin;
    end
  end

  // The whole pipe moves as one; a held output freezes every stage.
  assign w_adv   = !r_vld[NUM_SEG-1] || i_ready;
  assign o_ready = w_adv;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage

    if (k == 0) begin : g_src_in
      assign w_a[k]   = i_a;
      assign w_b[k]   = w_beff;
      assign w_c[k]   = w_ceff;
      assign w_sp[k]  = {WIDTH{1'b0}};
      assign w_vin[k] = i_valid;
    end else begin : g_src_prev
      assign w_a[k]   = r_a[k-1];
      assign w_b[k]   = r_b[k-1];
      assign w_c[k]   = r_c[k-1];
      assign w_sp[k]  = r_s[k-1];
      assign w_vin[k] = r_vld[k-1];
    end

    cp_rca_seg #(.SEG_W(SEG_W)) u_seg (
      .i_a  (w_a[k][SEG_W-1:0]),
      .i_b  (w_b[k][SEG_W-1:0]),
      .i_c  (w_c[k]),
      .o_s  (w_seg_s[k]),
      .o_co (w_seg_co[k]),
      .o_cm (w_seg_cm[k])
    );

    // Stage register: merge this slice into the partial sum and shift the
    // remaining operand bits down so the next stage always reads bit 0 up.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vld[k] <= 1'b0;
        r_s[k]   <= {WIDTH{1'b0}};
        r_a[k]   <= {WIDTH{1'b0}};
        r_b[k]   <= {WIDTH{1'b0}};
        r_c[k]   <= 1'b0;
      end else if (w_adv) begin
        r_vld[k] <= w_vin[k];
        r_s[k]   <= w_sp[k] | (WIDTH'(w_seg_s[k]) << (k * SEG_W));
        r_a[k]   <= w_a[k] >> SEG_W;
        r_b[k]   <= w_b[k] >> SEG_W;
        r_c[k]   <= w_seg_co[k];
      end
    end
  end

  // Overflow only exists at the top segment, where the MSB carries are seen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_seg_cm[NUM_SEG-1] ^ w_seg_co[NUM_SEG-1];
    end
  end

  assign o_valid = r_vld[NUM_SEG-1];
  assign o_s     = r_s[NUM_SEG-1];
  assign o_cy    = r_c[NUM_SEG-1];
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_cp_rca_pipe.sv
// -----------------------------------------------------------------------------
// tb_cp_rca_pipe
// Directed self-checking bench for cp_rca_pipe (WIDTH=16, SEG_W=4).
// -----------------------------------------------------------------------------
module tb_cp_rca_pipe;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        i_cin;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_s;
  logic        o_cy;
  logic        o_ovf;

  int n_checks = 0;
  int n_errors = 0;

  cp_rca_pipe #(.WIDTH(16), .SEG_W(4)) u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_s     (o_s),
    .o_cy    (o_cy),
    .o_ovf   (o_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {cy, ovf, s} computed with plain wide arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] t;
    logic        cy;
    logic        ov;
    if (!sub) begin
      t  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      cy = t[16];
      ov = (a[15] == b[15]) && (t[15] != a[15]);
    end else begin
      t  = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      cy = ~t[16];
      ov = (a[15] != b[15]) && (t[15] != a[15]);
    end
    return {cy, ov, t[15:0]};
  endfunction

  // One isolated operation: latency, sum, carry and overflow checks.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] es, input logic ecy, input logic eovf);
    int cnt;
    i_a = a; i_b = b; i_cin = cin; i_sub = sub; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    cnt = 1;
    while (!o_valid && cnt < 12) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'd4);
    chk({tag, "_s"},   32'(o_s),   32'(es));
    chk({tag, "_cy"},  32'(o_cy),  32'(ecy));
    chk({tag, "_ovf"}, 32'(o_ovf), 32'(eovf));
    @(posedge i_clk); #1;
  endtask

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vc [8];
  logic        vs [8];
  logic [17:0] q [$];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int          idx;
    int          nout;
    int          stall;
    int          stale;
    bit          stall_started;
    bit          acc;
    bit          hs;
    logic [15:0] held;
    logic [17:0] cur;
    logic [17:0] e;

    va[0] = 16'h0001; vb[0] = 16'h0002; vc[0] = 1'b0; vs[0] = 1'b0;
    va[1] = 16'h1000; vb[1] = 16'h0001; vc[1] = 1'b1; vs[1] = 1'b1;
    va[2] = 16'hFFFF; vb[2] = 16'hFFFF; vc[2] = 1'b1; vs[2] = 1'b0;
    va[3] = 16'h8000; vb[3] = 16'h7FFF; vc[3] = 1'b0; vs[3] = 1'b1;
    va[4] = 16'h1234; vb[4] = 16'h4321; vc[4] = 1'b0; vs[4] = 1'b0;
    va[5] = 16'h0000; vb[5] = 16'h0001; vc[5] = 1'b0; vs[5] = 1'b1;
    va[6] = 16'h4000; vb[6] = 16'h4000; vc[6] = 1'b0; vs[6] = 1'b0;
    va[7] = 16'hABCD; vb[7] = 16'hABCD; vc[7] = 1'b1; vs[7] = 1'b1;

    // 1. reset with i_valid held high
    i_rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    i_a = 16'hFFFF; i_b = 16'h0001; i_cin = 1'b0; i_sub = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_s",     32'(o_s),     32'd0);
    chk("rst_cy",    32'(o_cy),    32'd0);
    chk("rst_ovf",   32'(o_ovf),   32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // 2-4. directed arithmetic corners
    run_one("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_cin",  16'h1234, 16'h0234, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0);

    // 5. back-to-back with a 3-cycle output stall
    idx = 0; nout = 0; stall = 0; stall_started = 1'b0;
    for (int cyc = 0; cyc < 60 && nout < 8; cyc++) begin
      if (idx < 8) begin
        i_valid = 1'b1; i_a = va[idx]; i_b = vb[idx]; i_cin = vc[idx]; i_sub = vs[idx];
      end else begin
        i_valid = 1'b0;
      end
      if (o_valid && !stall_started) begin
        stall_started = 1'b1;
        stall = 3;
      end
      i_ready = (stall > 0) ? 1'b0 : 1'b1;
      #1;
      if (stall > 0) begin
        chk("stall_ready", 32'(o_ready), 32'd0);
      end
      held = o_s;
      cur  = {o_cy, o_ovf, o_s};
      acc  = i_valid && o_ready;
      hs   = o_valid && i_ready;
      @(posedge i_clk); #1;
      if (stall > 0) begin
        chk("stall_hold", 32'(o_s), 32'(held));
        stall--;
      end
      if (acc) begin
        q.push_back(model(va[idx], vb[idx], vc[idx], vs[idx]));
        idx++;
      end
      if (hs) begin
        if (q.size() == 0) begin
          chk("b2b_underflow", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("b2b_result", 32'(cur), 32'(e));
        end
        nout++;
      end
    end
    chk("b2b_accepted", 32'(idx), 32'd8);
    chk("b2b_outputs",  32'(nout), 32'd8);
    chk("b2b_drained",  32'(q.size()), 32'd0);
    chk("b2b_stalled",  32'(stall_started), 32'd1);
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // 6. reset with operations in flight and one held at the output
    i_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      i_valid = 1'b1; i_a = 16'h1111 * 16'(j + 1); i_b = 16'h2222; i_cin = 1'b0; i_sub = 1'b0;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    chk("inflight_valid", 32'(o_valid), 32'd1);
    chk("inflight_s",     32'(o_s),     32'h3333);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_s",     32'(o_s),     32'd0);
    chk("midrst_cy",    32'(o_cy),    32'd0);
    chk("midrst_ovf",   32'(o_ovf),   32'd0);
    chk("midrst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    stale = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge i_clk); #1;
      if (o_valid) stale++;
    end
    chk("no_stale", 32'(stale), 32'd0);
    run_one("post_rst", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
